l2_flush_walker: RTL

- Flush execution stage directly downstream of the L2 input decoder.
- Owns the flush bookkeeping registers (ongoing_flush, flush_set, flush_way) that the decoder reads.
- Applies the decoder's set/clear/increment strobes to those registers.
- On each do_ongoing_flush pulse, runs one way-step: reads the line state at (flush_set, flush_way), issues a PUT eviction if required, invalidates the line, and advances flush_way.

---
 rtl/l2_flush_walker_pkg.sv | 68 ++++++
 rtl/l2_flush_walker_if.sv | 57 +++++
 rtl/l2_flush_regs.sv | 80 ++++++++
 rtl/l2_flush_walker.sv | 136 +++++++++++++
 4 files changed

// File: rtl/l2_flush_walker_pkg.sv
// Shared cache constants and types for the L2 flush walker: geometry,
// line-state and eviction-message encodings, index types with a terminal
// bit, and helpers that build eviction addresses and messages.
package l2_flush_walker_pkg;

    localparam int SET_BITS  = 9;
    localparam int WAYS      = 8;
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int TAG_BITS  = 19;
    localparam int ADDR_BITS = 32;
    localparam int LINE_BITS = 128;
    localparam int L2_SETS   = 1 << SET_BITS;
    localparam int OFF_BITS  = ADDR_BITS - TAG_BITS - SET_BITS;

    // Set/way counters carry one extra bit so they can hold the terminal
    // values L2_SETS (walk finished) and WAYS (set finished).
    typedef logic [SET_BITS:0]       l2_set_t;
    typedef logic [WAY_BITS:0]       l2_way_t;
    typedef logic [SET_BITS-1:0]     set_idx_t;
    typedef logic [WAY_BITS-1:0]     way_idx_t;
    typedef logic [TAG_BITS-1:0]     tag_t;
    typedef logic [LINE_BITS-1:0]    line_t;
    typedef logic [ADDR_BITS-1:0]    addr_t;

    localparam l2_set_t SET_END = l2_set_t'(L2_SETS);
    localparam l2_way_t WAY_END = l2_way_t'(WAYS);

    // Line state as held in the L2 state array.
    typedef enum logic [1:0] {
        L2_INVALID   = 2'd0,
        L2_SHARED    = 2'd1,
        L2_EXCLUSIVE = 2'd2,
        L2_MODIFIED  = 2'd3
    } l2_state_t;

    // Eviction message sent towards the next level.
    typedef enum logic [1:0] {
        MSG_PUTS = 2'd0,
        MSG_PUTE = 2'd1,
        MSG_PUTM = 2'd2
    } put_msg_t;

    // Walker sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_EVAL   = 3'd2,
        ST_SEND   = 3'd3,
        ST_INV    = 3'd4
    } walk_state_t;

    // Line-aligned physical address of a (tag, set) pair.
    function automatic addr_t make_addr(input tag_t tag, input set_idx_t set);
        return {tag, set, {OFF_BITS{1'b0}}};
    endfunction

    // Eviction message for a valid line; only dirty lines carry data.
    function automatic logic [1:0] state_to_msg(input logic [1:0] st);
        logic [1:0] msg;
        case (st)
            L2_SHARED:    msg = MSG_PUTS;
            L2_EXCLUSIVE: msg = MSG_PUTE;
            default:      msg = MSG_PUTM;
        endcase
        return msg;
    endfunction

endpackage

// File: rtl/l2_flush_walker_if.sv
// Bundle of every non-clock signal of the flush walker: decoder strobes,
// flush bookkeeping outputs, array read/invalidate port and eviction
// request channel. The walker uses the master view.
interface l2_flush_walker_if;
    import l2_flush_walker_pkg::*;

    // Decoder strobes
    logic              set_ongoing_flush;
    logic              clr_ongoing_flush;
    logic              incr_flush_set;
    logic              clr_flush_set;
    logic              clr_flush_way;
    logic              flush_all;
    logic              do_ongoing_flush;

    // Flush bookkeeping
    logic              ongoing_flush;
    l2_set_t           flush_set;
    l2_way_t           flush_way;
    logic              walker_busy;

    // Array read / invalidate
    logic              rd_en;
    set_idx_t          rd_set;
    way_idx_t          rd_way;
    logic [1:0]        rd_state;
    logic              rd_hprot;
    tag_t              rd_tag;
    line_t             rd_line;
    logic              wr_inv_en;

    // Eviction request channel
    logic              req_out_valid;
    logic              req_out_ready;
    logic [1:0]        req_out_msg;
    addr_t             req_out_addr;
    line_t             req_out_line;

    modport master (
        input  set_ongoing_flush, clr_ongoing_flush, incr_flush_set,
               clr_flush_set, clr_flush_way, flush_all, do_ongoing_flush,
               rd_state, rd_hprot, rd_tag, rd_line, req_out_ready,
        output ongoing_flush, flush_set, flush_way, walker_busy,
               rd_en, rd_set, rd_way, wr_inv_en,
               req_out_valid, req_out_msg, req_out_addr, req_out_line
    );

    modport slave (
        output set_ongoing_flush, clr_ongoing_flush, incr_flush_set,
               clr_flush_set, clr_flush_way, flush_all, do_ongoing_flush,
               rd_state, rd_hprot, rd_tag, rd_line, req_out_ready,
        input  ongoing_flush, flush_set, flush_way, walker_busy,
               rd_en, rd_set, rd_way, wr_inv_en,
               req_out_valid, req_out_msg, req_out_addr, req_out_line
    );

endinterface

// File: rtl/l2_flush_regs.sv
// Flush bookkeeping registers read by the L2 input decoder: ongoing_flush,
// the captured flush_all mode, and the saturating set/way walk counters.
// Clear strobes always win over set/increment strobes in the same cycle.
module l2_flush_regs
    import l2_flush_walker_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    set_ongoing_flush_i,
    input  logic    clr_ongoing_flush_i,
    input  logic    flush_all_i,
    input  logic    incr_flush_set_i,
    input  logic    clr_flush_set_i,
    input  logic    incr_flush_way_i,
    input  logic    clr_flush_way_i,
    output logic    ongoing_flush_o,
    output logic    flush_all_o,
    output l2_set_t flush_set_o,
    output l2_way_t flush_way_o
);

    logic    ongoing_q, ongoing_d;
    logic    flush_all_q, flush_all_d;
    l2_set_t set_q, set_d;
    l2_way_t way_q, way_d;

    // Next-state: strobe priority and saturation at the terminal values.
    always_comb begin
        ongoing_d   = ongoing_q;
        flush_all_d = flush_all_q;
        set_d       = set_q;
        way_d       = way_q;

        if (set_ongoing_flush_i) begin
            ongoing_d = 1'b1;
        end
        if (clr_ongoing_flush_i) begin
            ongoing_d = 1'b0;
        end
        // The mode is fixed for the whole flush once it has started.
        if (set_ongoing_flush_i && !ongoing_q) begin
            flush_all_d = flush_all_i;
        end

        if (incr_flush_set_i && (set_q != SET_END)) begin
            set_d = set_q + l2_set_t'(1);
        end
        if (clr_flush_set_i) begin
            set_d = '0;
        end

        if (incr_flush_way_i && (way_q != WAY_END)) begin
            way_d = way_q + l2_way_t'(1);
        end
        if (clr_flush_way_i) begin
            way_d = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ongoing_q   <= 1'b0;
            flush_all_q <= 1'b0;
            set_q       <= '0;
            way_q       <= '0;
        end else begin
            ongoing_q   <= ongoing_d;
            flush_all_q <= flush_all_d;
            set_q       <= set_d;
            way_q       <= way_d;
        end
    end

    assign ongoing_flush_o = ongoing_q;
    assign flush_all_o     = flush_all_q;
    assign flush_set_o     = set_q;
    assign flush_way_o     = way_q;

endmodule

// File: rtl/l2_flush_walker.sv
// L2 flush execution stage. Each do_ongoing_flush pulse walks one way of
// the current set: read the line, evict it with PUTS/PUTE/PUTM if it is
// valid and selected by the flush mode, invalidate it, then advance the way.
module l2_flush_walker
    import l2_flush_walker_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    l2_flush_walker_if.master  bus
);

    // Bookkeeping register outputs
    logic        ongoing_flush;
    logic        flush_all_q;
    l2_set_t     flush_set;
    l2_way_t     flush_way;

    // Sequencer state and registered outputs
    walk_state_t state_q;
    logic        busy_q;
    logic        rd_en_q;
    set_idx_t    rd_set_q;
    way_idx_t    rd_way_q;
    logic        req_valid_q;
    logic [1:0]  msg_q;
    addr_t       addr_q;
    line_t       line_q;
    logic        wr_inv_q;

    logic        evict;
    logic        way_incr;

    l2_flush_regs u_regs (
        .clk                 (clk),
        .rst                 (rst),
        .set_ongoing_flush_i (bus.set_ongoing_flush),
        .clr_ongoing_flush_i (bus.clr_ongoing_flush),
        .flush_all_i         (bus.flush_all),
        .incr_flush_set_i    (bus.incr_flush_set),
        .clr_flush_set_i     (bus.clr_flush_set),
        .incr_flush_way_i    (way_incr),
        .clr_flush_way_i     (bus.clr_flush_way),
        .ongoing_flush_o     (ongoing_flush),
        .flush_all_o         (flush_all_q),
        .flush_set_o         (flush_set),
        .flush_way_o         (flush_way)
    );

    // A line needs eviction when valid and either every line is flushed or
    // it is a data line; the way advances on a skip or after invalidation.
    always_comb begin
        evict    = (bus.rd_state != L2_INVALID) && (flush_all_q || bus.rd_hprot);
        way_incr = 1'b0;
        if (state_q == ST_EVAL) begin
            way_incr = !evict;
        end else if (state_q == ST_INV) begin
            way_incr = 1'b1;
        end
    end

    // Way-step sequencer with registered strobes and request datapath.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_set_q    <= '0;
            rd_way_q    <= '0;
            req_valid_q <= 1'b0;
            msg_q       <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            wr_inv_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A finished set (flush_way == WAYS) ignores the pulse.
                    if (bus.do_ongoing_flush && (flush_way < WAY_END)) begin
                        state_q  <= ST_LOOKUP;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                        rd_set_q <= flush_set[SET_BITS-1:0];
                        rd_way_q <= flush_way[WAY_BITS-1:0];
                    end
                end
                ST_LOOKUP: begin
                    rd_en_q <= 1'b0;
                    state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (evict) begin
                        msg_q       <= state_to_msg(bus.rd_state);
                        addr_q      <= make_addr(bus.rd_tag, rd_set_q);
                        line_q      <= (bus.rd_state == L2_MODIFIED) ? bus.rd_line : '0;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_SEND;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // msg/addr/line are held until the request is accepted.
                    if (bus.req_out_ready) begin
                        req_valid_q <= 1'b0;
                        wr_inv_q    <= 1'b1;
                        state_q     <= ST_INV;
                    end
                end
                ST_INV: begin
                    wr_inv_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ongoing_flush = ongoing_flush;
    assign bus.flush_set     = flush_set;
    assign bus.flush_way     = flush_way;
    assign bus.walker_busy   = busy_q;
    assign bus.rd_en         = rd_en_q;
    assign bus.rd_set        = rd_set_q;
    assign bus.rd_way        = rd_way_q;
    assign bus.wr_inv_en     = wr_inv_q;
    assign bus.req_out_valid = req_valid_q;
    assign bus.req_out_msg   = msg_q;
    assign bus.req_out_addr  = addr_q;
    assign bus.req_out_line  = line_q;

endmodule
